// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared write-back types and constants for the register-file write arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SIZE   = 32;
  localparam int unsigned WB_ADDR_W = $clog2(WB_SIZE);

  // Port indices, also used as round-robin pointer values
  localparam logic WB_PORT_LSU = 1'b0;
  localparam logic WB_PORT_ALU = 1'b1;

  // One write-back request / buffered entry
  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry write-back holding buffer with ready generation.
// ready never looks at the incoming valid: it is only !full || grant.
module wb_hold_buf
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  wb_req_t              in_req,
  input  logic                 grant,
  output logic                 ready_c,
  output wb_req_t              buf_q,
  output logic                 nxt_full_c,
  output logic [WB_ADDR_W-1:0] nxt_addr_c
);

  wb_req_t buf_d;

  // Drain on grant, load (or reload over a drain) on handshake
  always_comb begin
    ready_c = !buf_q.valid || grant;
    buf_d   = buf_q;
    if (grant) begin
      buf_d.valid = 1'b0;
    end
    if (in_req.valid && ready_c) begin
      buf_d = in_req;
    end
    nxt_full_c = buf_d.valid;
    nxt_addr_c = buf_d.addr;
  end

  // Entry register
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: LSU (port 0) and ALU (port 1) into one register file
// write port, with a registered write command and pending-write mask.
// Define WB_RR_ARB_EN for round-robin arbitration; default is fixed
// priority with the LSU always winning.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH  = WB_DATA_W,
  parameter int unsigned SIZE   = WB_SIZE,
  parameter int unsigned ADDR_W = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [WIDTH-1:0]  lsu_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [WIDTH-1:0]  alu_data,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [WIDTH-1:0]  write_data,
  output logic [SIZE-1:0]   pending_mask
);

  wb_req_t              lsu_in, alu_in;
  wb_req_t              lsu_buf, alu_buf;
  wb_req_t              win_req;
  logic                 lsu_grant, alu_grant, win_alu;
  logic                 lsu_nxt_full, alu_nxt_full;
  logic [WB_ADDR_W-1:0] lsu_nxt_addr, alu_nxt_addr;

  logic              write_enable_d, write_enable_q;
  logic [ADDR_W-1:0] write_addr_d, write_addr_q;
  logic [WIDTH-1:0]  write_data_d, write_data_q;
  logic [SIZE-1:0]   pending_mask_d, pending_mask_q;

  // Pack port inputs into request structs
  always_comb begin
    lsu_in = '{valid: lsu_valid, addr: WB_ADDR_W'(lsu_addr), data: WB_DATA_W'(lsu_data)};
    alu_in = '{valid: alu_valid, addr: WB_ADDR_W'(alu_addr), data: WB_DATA_W'(alu_data)};
  end

  wb_hold_buf u_lsu_buf (
    .clk        (clk),
    .reset      (reset),
    .in_req     (lsu_in),
    .grant      (lsu_grant),
    .ready_c    (lsu_ready),
    .buf_q      (lsu_buf),
    .nxt_full_c (lsu_nxt_full),
    .nxt_addr_c (lsu_nxt_addr)
  );

  wb_hold_buf u_alu_buf (
    .clk        (clk),
    .reset      (reset),
    .in_req     (alu_in),
    .grant      (alu_grant),
    .ready_c    (alu_ready),
    .buf_q      (alu_buf),
    .nxt_full_c (alu_nxt_full),
    .nxt_addr_c (alu_nxt_addr)
  );

`ifdef WB_RR_ARB_EN
  logic rr_d, rr_q;

  // Round-robin winner select; pointer flips only after a contested grant
  always_comb begin
    rr_d    = rr_q;
    win_alu = alu_buf.valid;
    if (lsu_buf.valid && alu_buf.valid) begin
      win_alu = (rr_q == WB_PORT_ALU);
      rr_d    = win_alu ? WB_PORT_LSU : WB_PORT_ALU;
    end
  end

  // Preferred-port pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= WB_PORT_LSU;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // Fixed priority: ALU only wins when the LSU buffer is empty
  always_comb begin
    win_alu = alu_buf.valid && !lsu_buf.valid;
  end
`endif

  // Grants and the winning entry; win_req.valid is set iff any grant occurs
  always_comb begin
    lsu_grant = lsu_buf.valid && !win_alu;
    alu_grant = alu_buf.valid && win_alu;
    win_req   = win_alu ? alu_buf : lsu_buf;
  end

  // Next write command and pending mask, built from next-state buffers
  always_comb begin
    write_enable_d = 1'b0;
    write_addr_d   = write_addr_q;
    write_data_d   = write_data_q;
    if (win_req.valid) begin
      write_addr_d   = ADDR_W'(win_req.addr);
      write_data_d   = WIDTH'(win_req.data);
      write_enable_d = (win_req.addr != '0);
    end
    pending_mask_d = '0;
    for (int unsigned r = 1; r < SIZE; r++) begin
      pending_mask_d[r] = (lsu_nxt_full && (lsu_nxt_addr == WB_ADDR_W'(r))) ||
                          (alu_nxt_full && (alu_nxt_addr == WB_ADDR_W'(r))) ||
                          (write_enable_d && (write_addr_d == ADDR_W'(r)));
    end
  end

  // Output stage registers
  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable_q <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= '0;
      pending_mask_q <= '0;
    end else begin
      write_enable_q <= write_enable_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
      pending_mask_q <= pending_mask_d;
    end
  end

  assign write_enable = write_enable_q;
  assign write_addr   = write_addr_q;
  assign write_data   = write_data_q;
  assign pending_mask = pending_mask_q;

endmodule
